// File: rtl/key_sequence_checker.sv
// Memory-game round checker: asks SEQ_LEN codes and judges each pressed key
// against a programmable code->key map, with a per-key timeout and a final score.
module key_sequence_checker #(
  parameter int KEY_W       = 4,
  parameter int SEQ_LEN     = 4,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [KEY_W-1:0]               code_in,
  input  logic                           key_valid,
  input  logic [KEY_W-1:0]               key_value,
  input  logic                           map_we,
  input  logic [KEY_W-1:0]               map_addr,
  input  logic [KEY_W-1:0]               map_data,
  output logic [KEY_W-1:0]               cur_code,
  output logic                           busy,
  output logic                           correct,
  output logic                           wrong,
  output logic                           timeout,
  output logic                           done,
  output logic [$clog2(SEQ_LEN+1)-1:0]   score,
  output logic                           perfect
);

  localparam int DEPTH   = 1 << KEY_W;
  localparam int SCORE_W = $clog2(SEQ_LEN + 1);
  localparam int IDX_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int TIMER_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(SEQ_LEN - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [SCORE_W-1:0] FULL_SCR  = SCORE_W'(SEQ_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_KEY,
    S_DONE
  } state_e;

  // Power-on mapping: the scrambled keypad table for 4-bit codes, identity otherwise.
  function automatic logic [KEY_W-1:0] default_key(input int code);
    logic [KEY_W-1:0] key;
    key = KEY_W'(code);
    if (KEY_W == 4) begin
      case (code)
        0:       key = KEY_W'(14);
        1:       key = KEY_W'(1);
        2:       key = KEY_W'(4);
        3:       key = KEY_W'(9);
        4:       key = KEY_W'(8);
        5:       key = KEY_W'(10);
        6:       key = KEY_W'(2);
        7:       key = KEY_W'(6);
        8:       key = KEY_W'(15);
        9:       key = KEY_W'(0);
        10:      key = KEY_W'(7);
        11:      key = KEY_W'(3);
        12:      key = KEY_W'(5);
        13:      key = KEY_W'(13);
        14:      key = KEY_W'(11);
        15:      key = KEY_W'(12);
        default: key = KEY_W'(code);
      endcase
    end
    return key;
  endfunction

  state_e               state_q, state_d;
  logic [KEY_W-1:0]     cur_code_q, cur_code_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 perfect_q, perfect_d;
  logic                 correct_q, correct_d;
  logic                 wrong_q, wrong_d;
  logic                 timeout_q, timeout_d;
  logic [KEY_W-1:0]     map_q [DEPTH];
  logic                 key_ok;
  logic                 advance;

  // NOTE: the map has a reset image, so it must live in flops; a RAM macro cannot be reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        map_q[i] <= default_key(i);
      end
    end else if (map_we && state_q == S_IDLE) begin
      map_q[map_addr] <= map_data;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    score_d    = score_q;
    perfect_d  = perfect_q;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;
    timeout_d  = 1'b0;
    advance    = 1'b0;
    key_ok     = (key_value == map_q[cur_code_q]);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_code_d = code_in;
          idx_d      = '0;
          score_d    = '0;
          timer_d    = '0;
          perfect_d  = 1'b0;
          state_d    = S_WAIT_KEY;
        end
      end

      S_WAIT_KEY: begin
        // A key arriving on the last allowed cycle wins over the timeout.
        if (key_valid) begin
          advance   = 1'b1;
          correct_d = key_ok;
          wrong_d   = ~key_ok;
          score_d   = score_q + SCORE_W'(key_ok);
        end else if (timer_q == TIMER_MAX) begin
          advance   = 1'b1;
          timeout_d = 1'b1;
          wrong_d   = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end

        if (advance) begin
          timer_d    = '0;
          cur_code_d = code_in;
          if (idx_q == LAST_IDX) begin
            state_d   = S_DONE;
            perfect_d = (score_d == FULL_SCR);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cur_code_q <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      score_q    <= '0;
      perfect_q  <= 1'b0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      score_q    <= score_d;
      perfect_q  <= perfect_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cur_code = cur_code_q;
  assign busy     = (state_q == S_WAIT_KEY);
  assign done     = (state_q == S_DONE);
  assign correct  = correct_q;
  assign wrong    = wrong_q;
  assign timeout  = timeout_q;
  assign score    = score_q;
  assign perfect  = perfect_q;

endmodule

// File: tb/tb_key_sequence_checker.sv
// Directed scoreboard bench for key_sequence_checker (KEY_W=4, SEQ_LEN=4, TIMEOUT_CYC=16).
module tb_key_sequence_checker;

  typedef struct packed {
    logic       correct;
    logic       wrong;
    logic       timeout;
    logic       done;
    logic       perfect;
    logic [2:0] score;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] code_in;
  logic       key_valid;
  logic [3:0] key_value;
  logic       map_we;
  logic [3:0] map_addr;
  logic [3:0] map_data;
  logic [3:0] cur_code;
  logic       busy;
  logic       correct;
  logic       wrong;
  logic       timeout;
  logic       done;
  logic [2:0] score;
  logic       perfect;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q [$];
  ev_t  mon_act;
  ev_t  mon_exp;
  logic [2:0] exp_score;

  key_sequence_checker #(
    .KEY_W      (4),
    .SEQ_LEN    (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .code_in  (code_in),
    .key_valid(key_valid),
    .key_value(key_value),
    .map_we   (map_we),
    .map_addr (map_addr),
    .map_data (map_data),
    .cur_code (cur_code),
    .busy     (busy),
    .correct  (correct),
    .wrong    (wrong),
    .timeout  (timeout),
    .done     (done),
    .score    (score),
    .perfect  (perfect)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && (correct || wrong || timeout || done)) begin
      mon_act = {correct, wrong, timeout, done, perfect, score};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got %b (c w t d p score) expected no event", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL event got %b expected %b (c w t d p score)", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic c, input logic w, input logic t, input logic d,
                         input logic p, input logic [2:0] s);
    ev_t e;
    e = {c, w, t, d, p, s};
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [3:0] code);
    start     = 1'b1;
    code_in   = code;
    exp_score = 3'd0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] key, input logic [3:0] next_code,
                       input logic ok, input logic last);
    key_valid = 1'b1;
    key_value = key;
    code_in   = next_code;
    if (ok) exp_score = exp_score + 3'd1;
    push_ev(ok, ~ok, 1'b0, last, last && (exp_score == 3'd4), exp_score);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    code_in   = '0;
    key_valid = 1'b0;
    key_value = '0;
    map_we    = 1'b0;
    map_addr  = '0;
    map_data  = '0;
    exp_score = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pulses", {correct, wrong, timeout, done}, 0);
    check("rst_score", score, 0);
    check("rst_perfect", perfect, 0);
    check("rst_cur_code", cur_code, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Perfect round: codes 0,3,8,15 with keys 14,9,15,12.
    do_start(4'd0);
    check("perf_busy", busy, 1);
    check("perf_cur_code", cur_code, 0);
    press(4'd14, 4'd3, 1'b1, 1'b0);
    press(4'd9, 4'd8, 1'b1, 1'b0);
    press(4'd15, 4'd15, 1'b1, 1'b0);
    press(4'd12, 4'd0, 1'b1, 1'b1);
    check("perf_done", done, 1);
    check("perf_busy_done", busy, 0);
    repeat (3) @(negedge clk);
    check("hold_score", score, 4);
    check("hold_perfect", perfect, 1);
    check("hold_done_low", done, 0);

    // A key in IDLE must be ignored (monitor flags any pulse).
    key_valid = 1'b1;
    key_value = 4'd14;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    check("idle_key_score", score, 4);

    // Mixed round: codes 1,2,5,6 with keys 1,7,10,3; start mid-round is ignored.
    do_start(4'd1);
    check("mix_score_clr", score, 0);
    check("mix_perfect_clr", perfect, 0);
    press(4'd1, 4'd2, 1'b1, 1'b0);
    start   = 1'b1;
    code_in = 4'd5;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ign_score", score, 1);
    check("busy_start_ign_code", cur_code, 2);
    press(4'd7, 4'd5, 1'b0, 1'b0);
    press(4'd10, 4'd6, 1'b1, 1'b0);
    press(4'd3, 4'd0, 1'b0, 1'b1);
    check("mix_score", score, 2);
    check("mix_perfect", perfect, 0);
    @(negedge clk);

    // Timeout round: no keys at all, four timeouts in a row.
    do_start(4'd2);
    code_in = 4'd9;
    for (int i = 0; i < 4; i++) begin
      push_ev(1'b0, 1'b1, 1'b1, (i == 3), 1'b0, 3'd0);
    end
    repeat (15) @(negedge clk);
    check("to_not_early", timeout, 0);
    check("to_code_before", cur_code, 2);
    @(negedge clk);
    check("to_pulse", timeout, 1);
    check("to_wrong", wrong, 1);
    check("to_code_reload", cur_code, 9);
    check("to_still_busy", busy, 1);
    repeat (48) @(negedge clk);
    check("to_done", done, 1);
    check("to_score", score, 0);
    @(negedge clk);

    // Key arriving on the timeout cycle: judged as a key, no timeout.
    do_start(4'd0);
    repeat (15) @(negedge clk);
    press(4'd14, 4'd0, 1'b1, 1'b0);
    check("kt_no_timeout", timeout, 0);
    check("kt_correct", correct, 1);
    press(4'd0, 4'd0, 1'b0, 1'b0);
    press(4'd0, 4'd0, 1'b0, 1'b0);
    press(4'd0, 4'd0, 1'b0, 1'b1);
    check("kt_score", score, 1);
    @(negedge clk);

    // Map writes: idle write 0<-5, write 3<-0 together with start, busy write ignored.
    map_we   = 1'b1;
    map_addr = 4'd0;
    map_data = 4'd5;
    @(negedge clk);
    map_addr = 4'd3;
    map_data = 4'd0;
    do_start(4'd0);
    map_we = 1'b0;
    press(4'd5, 4'd3, 1'b1, 1'b0);
    map_we   = 1'b1;
    map_addr = 4'd0;
    map_data = 4'd9;
    @(negedge clk);
    map_we = 1'b0;
    press(4'd0, 4'd0, 1'b1, 1'b0);
    press(4'd5, 4'd0, 1'b1, 1'b0);
    press(4'd5, 4'd0, 1'b1, 1'b1);
    check("map_perfect", perfect, 1);
    @(negedge clk);

    // Reset mid-round after two correct keys.
    do_start(4'd1);
    press(4'd1, 4'd6, 1'b1, 1'b0);
    press(4'd2, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_pulses", {correct, wrong, timeout, done}, 0);
    check("mrst_score", score, 0);
    check("mrst_perfect", perfect, 0);
    check("mrst_cur_code", cur_code, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_no_done", done, 0);

    // Default map restored: code 0 expects 14 again.
    do_start(4'd0);
    press(4'd14, 4'd0, 1'b1, 1'b0);
    press(4'd14, 4'd0, 1'b1, 1'b0);
    press(4'd14, 4'd0, 1'b1, 1'b0);
    press(4'd14, 4'd0, 1'b1, 1'b1);
    check("restored_perfect", perfect, 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
